// File: rtl/z80_ext_bus_ctrl_if.sv
// Signal bundle between the Z80 socket controller, the top-level pins and the system bus.
// master = the controller, slave = whatever surrounds it (pins, bus fabric, bench).
interface z80_ext_bus_ctrl_if;
    logic        z80_clk;
    logic        z80_reset_n;
    logic        z80_int_n;
    logic        z80_nmi_n;
    logic        nmi_req;
    logic        z80_m1_n;
    logic        z80_mreq_n;
    logic        z80_iorq_n;
    logic        z80_rd_n;
    logic        z80_wr_n;
    logic [15:0] z80_a;
    logic [7:0]  z80_d_in;
    logic [7:0]  z80_d_out;
    logic        z80_d_oe;
    logic [15:0] bus_addr;
    logic        bus_is_io;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_din;
    logic [7:0]  bus_dout;

    modport master (
        output z80_clk, z80_reset_n, z80_int_n, z80_nmi_n, z80_d_out, z80_d_oe,
        output bus_addr, bus_is_io, bus_rd, bus_wr, bus_dout,
        input  nmi_req, z80_m1_n, z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n,
        input  z80_a, z80_d_in, bus_din
    );

    modport slave (
        input  z80_clk, z80_reset_n, z80_int_n, z80_nmi_n, z80_d_out, z80_d_oe,
        input  bus_addr, bus_is_io, bus_rd, bus_wr, bus_dout,
        output nmi_req, z80_m1_n, z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n,
        output z80_a, z80_d_in, bus_din
    );
endinterface

// File: rtl/z80_ext_bus_ctrl.sv
// Drives the external Z80 socket: clock, reset/INT/NMI timing, and translation of Z80
// machine cycles into single-clk strobes on the internal bus with data-bus direction control.
module z80_ext_bus_ctrl #(
    parameter int         CLK_DIV       = 4,
    parameter int         RESET_TSTATES = 16,
    parameter int         INT_PERIOD    = 69888,
    parameter int         INT_WIDTH     = 32,
    parameter int         NMI_WIDTH     = 16,
    parameter logic [7:0] INTA_VECTOR   = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    z80_ext_bus_ctrl_if.master  bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int RW = $clog2(RESET_TSTATES + 1);
    localparam int TW = $clog2(INT_PERIOD + 1);
    localparam int NW = $clog2(NMI_WIDTH + 1);

    typedef enum logic {HOLD, RUN} rstate_t;
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_DONE, INTA_DRIVE, WAIT_END} cyc_t;

    logic [DW-1:0] div_q, div_d;
    logic          z80_clk_q, z80_clk_d;
    rstate_t       rstate_q, rstate_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          int_n_q, int_n_d;
    logic [NW-1:0] ncnt_q, ncnt_d;
    logic          nmi_n_q, nmi_n_d;
    cyc_t          cyc_q, cyc_d;
    logic          rd_phase_q, rd_phase_d;
    logic          bus_rd_q, bus_rd_d, bus_wr_q, bus_wr_d;
    logic [15:0]   addr_q, addr_d;
    logic          is_io_q, is_io_d;
    logic [7:0]    dout_q, dout_d, d_out_q, d_out_d;
    logic          oe_q, oe_d;
    logic          tick, inta_rec, enter_run;

    // Bit order: 4=M1, 3=MREQ, 2=IORQ, 1=RD, 0=WR (all active low at the pins)
    logic [4:0] async_n, meta_q, sync_q;
    assign async_n = {bus.z80_m1_n, bus.z80_mreq_n, bus.z80_iorq_n, bus.z80_rd_n, bus.z80_wr_n};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q[gi] <= 1'b1;
                    sync_q[gi] <= 1'b1;
                end else begin
                    meta_q[gi] <= async_n[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    logic m1, mreq, iorq, rd, wr;
    assign {m1, mreq, iorq, rd, wr} = ~sync_q;

    always_comb begin
        tick      = (div_q == DW'(CLK_DIV - 1));
        div_d     = tick ? '0 : div_q + 1'b1;
        z80_clk_d = (div_d < DW'(CLK_DIV / 2));

        rstate_d  = rstate_q;
        rcnt_d    = rcnt_q;
        enter_run = 1'b0;
        if (rstate_q == HOLD && tick) begin
            if (rcnt_q == RW'(RESET_TSTATES - 1)) begin
                rstate_d  = RUN;
                rcnt_d    = '0;
                enter_run = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        cyc_d      = cyc_q;
        rd_phase_d = rd_phase_q;
        bus_rd_d   = 1'b0;
        bus_wr_d   = 1'b0;
        addr_d     = addr_q;
        is_io_d    = is_io_q;
        dout_d     = dout_q;
        d_out_d    = d_out_q;
        oe_d       = oe_q;
        inta_rec   = 1'b0;
        case (cyc_q)
            IDLE: begin
                if (iorq && m1) begin
                    d_out_d  = INTA_VECTOR;
                    oe_d     = 1'b1;
                    inta_rec = 1'b1;
                    cyc_d    = INTA_DRIVE;
                end else if (rd && (mreq || (iorq && !m1))) begin
                    addr_d     = bus.z80_a;
                    is_io_d    = !mreq;
                    bus_rd_d   = 1'b1;
                    rd_phase_d = 1'b0;
                    cyc_d      = RD_WAIT;
                end else if (wr && (mreq || iorq)) begin
                    addr_d   = bus.z80_a;
                    dout_d   = bus.z80_d_in;
                    is_io_d  = !mreq;
                    bus_wr_d = 1'b1;
                    cyc_d    = WR_DONE;
                end
            end
            // bus_din arrives one clk after the clk in which the strobe was seen, so wait two clks
            RD_WAIT: begin
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d = 1'b0;
                    d_out_d    = bus.bus_din;
                    oe_d       = 1'b1;
                    cyc_d      = RD_DRIVE;
                end
            end
            RD_DRIVE, INTA_DRIVE: begin
                if (!rd && !iorq) begin
                    oe_d  = 1'b0;
                    cyc_d = IDLE;
                end
            end
            WR_DONE:  cyc_d = WAIT_END;
            WAIT_END: if (!mreq && !iorq && !rd && !wr) cyc_d = IDLE;
            default:  cyc_d = IDLE;
        endcase
        if (rstate_q == HOLD) begin
            cyc_d      = IDLE;
            oe_d       = 1'b0;
            bus_rd_d   = 1'b0;
            bus_wr_d   = 1'b0;
            rd_phase_d = 1'b0;
            inta_rec   = 1'b0;
        end

        // Acknowledge first so that a simultaneous period wrap re-asserts INT
        tcnt_d  = tcnt_q;
        int_n_d = int_n_q;
        if (inta_rec) int_n_d = 1'b1;
        if (enter_run) begin
            tcnt_d  = '0;
            int_n_d = 1'b0;
        end else if (rstate_q == HOLD) begin
            tcnt_d  = '0;
            int_n_d = 1'b1;
        end else if (tick) begin
            tcnt_d = (tcnt_q == TW'(INT_PERIOD - 1)) ? '0 : tcnt_q + 1'b1;
            if (tcnt_d == '0)                 int_n_d = 1'b0;
            else if (tcnt_d == TW'(INT_WIDTH)) int_n_d = 1'b1;
        end

        ncnt_d  = ncnt_q;
        nmi_n_d = nmi_n_q;
        if (rstate_q == HOLD) begin
            ncnt_d  = '0;
            nmi_n_d = 1'b1;
        end else if (nmi_n_q) begin
            if (bus.nmi_req) begin
                ncnt_d  = '0;
                nmi_n_d = 1'b0;
            end
        end else if (tick) begin
            if (ncnt_q == NW'(NMI_WIDTH - 1)) begin
                ncnt_d  = '0;
                nmi_n_d = 1'b1;
            end else begin
                ncnt_d = ncnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            z80_clk_q  <= 1'b1;
            rstate_q   <= HOLD;
            rcnt_q     <= '0;
            tcnt_q     <= '0;
            int_n_q    <= 1'b1;
            ncnt_q     <= '0;
            nmi_n_q    <= 1'b1;
            cyc_q      <= IDLE;
            rd_phase_q <= 1'b0;
            bus_rd_q   <= 1'b0;
            bus_wr_q   <= 1'b0;
            addr_q     <= '0;
            is_io_q    <= 1'b0;
            dout_q     <= '0;
            d_out_q    <= '0;
            oe_q       <= 1'b0;
        end else begin
            div_q      <= div_d;
            z80_clk_q  <= z80_clk_d;
            rstate_q   <= rstate_d;
            rcnt_q     <= rcnt_d;
            tcnt_q     <= tcnt_d;
            int_n_q    <= int_n_d;
            ncnt_q     <= ncnt_d;
            nmi_n_q    <= nmi_n_d;
            cyc_q      <= cyc_d;
            rd_phase_q <= rd_phase_d;
            bus_rd_q   <= bus_rd_d;
            bus_wr_q   <= bus_wr_d;
            addr_q     <= addr_d;
            is_io_q    <= is_io_d;
            dout_q     <= dout_d;
            d_out_q    <= d_out_d;
            oe_q       <= oe_d;
        end
    end

    assign bus.z80_clk     = z80_clk_q;
    assign bus.z80_reset_n = (rstate_q == RUN);
    assign bus.z80_int_n   = int_n_q;
    assign bus.z80_nmi_n   = nmi_n_q;
    assign bus.z80_d_out   = d_out_q;
    assign bus.z80_d_oe    = oe_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_is_io   = is_io_q;
    assign bus.bus_rd      = bus_rd_q;
    assign bus.bus_wr      = bus_wr_q;
    assign bus.bus_dout    = dout_q;
endmodule

// File: tb/tb_z80_ext_bus_ctrl.sv
// Directed bench for z80_ext_bus_ctrl with short INT timing (INT_PERIOD=100, INT_WIDTH=8).
module tb_z80_ext_bus_ctrl;
    localparam int INT_LOW_CLK    = 8 * 4;
    localparam int INT_PERIOD_CLK = 100 * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    z80_ext_bus_ctrl_if bus_if();

    z80_ext_bus_ctrl #(.INT_PERIOD(100), .INT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Bus-side responder: registered read data, valid the clk after bus_rd
    logic [7:0] rd_value = 8'h00;
    always @(posedge clk) bus_if.bus_din <= bus_if.bus_rd ? rd_value : 8'h00;

    int          rd_cnt = 0, wr_cnt = 0;
    logic [15:0] last_rd_addr, last_wr_addr;
    logic        last_rd_io, last_wr_io;
    logic [7:0]  last_wr_dout;
    always @(negedge clk) begin
        if (bus_if.bus_rd) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= bus_if.bus_addr;
            last_rd_io   <= bus_if.bus_is_io;
        end
        if (bus_if.bus_wr) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus_if.bus_addr;
            last_wr_io   <= bus_if.bus_is_io;
            last_wr_dout <= bus_if.bus_dout;
        end
    end

    task automatic test_reset();
        logic exp_clk;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus_if.z80_reset_n !== 1'b0) begin n_fail++; $display("FAIL rst_reset_n got %b want 0", bus_if.z80_reset_n); end
        n_checks++; if (bus_if.z80_int_n !== 1'b1) begin n_fail++; $display("FAIL rst_int_n got %b want 1", bus_if.z80_int_n); end
        n_checks++; if (bus_if.z80_nmi_n !== 1'b1) begin n_fail++; $display("FAIL rst_nmi_n got %b want 1", bus_if.z80_nmi_n); end
        n_checks++; if (bus_if.z80_d_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", bus_if.z80_d_oe); end
        n_checks++; if ({bus_if.bus_rd, bus_if.bus_wr} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b%b want 00", bus_if.bus_rd, bus_if.bus_wr); end
        n_checks++; if (bus_if.z80_clk !== 1'b1) begin n_fail++; $display("FAIL rst_z80_clk got %b want 1", bus_if.z80_clk); end
        n_checks++; if ({bus_if.z80_d_out, bus_if.bus_addr, bus_if.bus_is_io, bus_if.bus_dout} !== 33'd0) begin
            n_fail++; $display("FAIL rst_data got d_out=%h addr=%h io=%b dout=%h want zeros", bus_if.z80_d_out, bus_if.bus_addr, bus_if.bus_is_io, bus_if.bus_dout);
        end
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            bus_if.nmi_req = (k == 20);
            exp_clk = ((k % 4) < 2);
            n_checks++; if (bus_if.z80_clk !== exp_clk) begin n_fail++; $display("FAIL seq_z80_clk clk=%0d got %b want %b", k, bus_if.z80_clk, exp_clk); end
            n_checks++; if (bus_if.z80_reset_n !== (k >= 64)) begin n_fail++; $display("FAIL seq_reset_n clk=%0d got %b want %b", k, bus_if.z80_reset_n, (k >= 64)); end
            n_checks++; if (bus_if.z80_d_oe !== 1'b0) begin n_fail++; $display("FAIL seq_oe clk=%0d got %b want 0", k, bus_if.z80_d_oe); end
            n_checks++; if (bus_if.z80_nmi_n !== 1'b1) begin n_fail++; $display("FAIL hold_nmi clk=%0d got %b want 1", k, bus_if.z80_nmi_n); end
        end
        bus_if.nmi_req = 1'b0;
        $display("reset: z80_reset_n released after 64 clk (16 ticks)");
    endtask

    task automatic test_int_timing();
        int cnt;
        n_checks++; if (bus_if.z80_int_n !== 1'b0) begin n_fail++; $display("FAIL int_first got %b want 0", bus_if.z80_int_n); end
        cnt = 0;
        while (bus_if.z80_int_n !== 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
        n_checks++; if (cnt != INT_LOW_CLK) begin n_fail++; $display("FAIL int_low1 got %0d clk want %0d", cnt, INT_LOW_CLK); end
        cnt = 0;
        while (bus_if.z80_int_n !== 1'b0 && cnt < 1000) begin @(negedge clk); cnt++; end
        n_checks++; if (cnt != INT_PERIOD_CLK - INT_LOW_CLK) begin n_fail++; $display("FAIL int_high got %0d clk want %0d", cnt, INT_PERIOD_CLK - INT_LOW_CLK); end
        cnt = 0;
        while (bus_if.z80_int_n !== 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
        n_checks++; if (cnt != INT_LOW_CLK) begin n_fail++; $display("FAIL int_low2 got %0d clk want %0d", cnt, INT_LOW_CLK); end
        $display("int: low %0d clk, period %0d clk", INT_LOW_CLK, INT_PERIOD_CLK);
    endtask

    task automatic test_mem_read();
        int lat, rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(negedge clk);
        rd_value = 8'hA5;
        bus_if.z80_a = 16'h4000;
        bus_if.z80_mreq_n = 1'b0;
        bus_if.z80_rd_n = 1'b0;
        lat = 0;
        while (bus_if.z80_d_oe !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
        n_checks++; if (lat > 5) begin n_fail++; $display("FAIL mrd_latency got %0d clk want <=5", lat); end
        n_checks++; if (bus_if.z80_d_out !== 8'hA5) begin n_fail++; $display("FAIL mrd_data got %h want a5", bus_if.z80_d_out); end
        repeat (4) @(negedge clk);
        n_checks++; if (bus_if.z80_d_oe !== 1'b1) begin n_fail++; $display("FAIL mrd_hold_oe got %b want 1", bus_if.z80_d_oe); end
        bus_if.z80_mreq_n = 1'b1;
        bus_if.z80_rd_n = 1'b1;
        lat = 0;
        while (bus_if.z80_d_oe !== 1'b0 && lat < 6) begin @(negedge clk); lat++; end
        n_checks++; if (lat > 3) begin n_fail++; $display("FAIL mrd_release got %0d clk want <=3", lat); end
        repeat (4) @(negedge clk);
        n_checks++; if (rd_cnt - rd0 != 1) begin n_fail++; $display("FAIL mrd_rd_count got %0d want 1", rd_cnt - rd0); end
        n_checks++; if (wr_cnt - wr0 != 0) begin n_fail++; $display("FAIL mrd_wr_count got %0d want 0", wr_cnt - wr0); end
        n_checks++; if (last_rd_addr !== 16'h4000) begin n_fail++; $display("FAIL mrd_addr got %h want 4000", last_rd_addr); end
        n_checks++; if (last_rd_io !== 1'b0) begin n_fail++; $display("FAIL mrd_is_io got %b want 0", last_rd_io); end
        $display("mem read: addr=4000 data=a5");
    endtask

    task automatic test_io_write();
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(negedge clk);
        bus_if.z80_a = 16'h00FE;
        bus_if.z80_d_in = 8'h07;
        bus_if.z80_iorq_n = 1'b0;
        bus_if.z80_wr_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++; if (bus_if.z80_d_oe !== 1'b0) begin n_fail++; $display("FAIL iowr_oe clk=%0d got %b want 0", i, bus_if.z80_d_oe); end
        end
        bus_if.z80_iorq_n = 1'b1;
        bus_if.z80_wr_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (wr_cnt - wr0 != 1) begin n_fail++; $display("FAIL iowr_wr_count got %0d want 1", wr_cnt - wr0); end
        n_checks++; if (rd_cnt - rd0 != 0) begin n_fail++; $display("FAIL iowr_rd_count got %0d want 0", rd_cnt - rd0); end
        n_checks++; if (last_wr_io !== 1'b1) begin n_fail++; $display("FAIL iowr_is_io got %b want 1", last_wr_io); end
        n_checks++; if (last_wr_dout !== 8'h07) begin n_fail++; $display("FAIL iowr_dout got %h want 07", last_wr_dout); end
        n_checks++; if (last_wr_addr !== 16'h00FE) begin n_fail++; $display("FAIL iowr_addr got %h want 00fe", last_wr_addr); end
        $display("io write: addr=00fe data=07");
    endtask

    task automatic test_inta();
        int cnt, rd0, wr0;
        logic prev;
        rd0 = rd_cnt; wr0 = wr_cnt;
        cnt = 0;
        while (bus_if.z80_int_n !== 1'b1 && cnt < 500) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (bus_if.z80_int_n !== 1'b0 && cnt < 500) begin @(negedge clk); cnt++; end
        prev = bus_if.z80_clk;
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 3; i++) begin
            @(negedge clk);
            if (!prev && bus_if.z80_clk) cnt++;
            prev = bus_if.z80_clk;
        end
        n_checks++; if (bus_if.z80_int_n !== 1'b0) begin n_fail++; $display("FAIL inta_pre_int got %b want 0", bus_if.z80_int_n); end
        bus_if.z80_m1_n = 1'b0;
        bus_if.z80_iorq_n = 1'b0;
        cnt = 0;
        while (bus_if.z80_d_oe !== 1'b1 && cnt < 8) begin @(negedge clk); cnt++; end
        n_checks++; if (cnt > 5) begin n_fail++; $display("FAIL inta_latency got %0d clk want <=5", cnt); end
        n_checks++; if (bus_if.z80_int_n !== 1'b1) begin n_fail++; $display("FAIL inta_int_n got %b want 1", bus_if.z80_int_n); end
        n_checks++; if (bus_if.z80_d_out !== 8'hFF) begin n_fail++; $display("FAIL inta_vector got %h want ff", bus_if.z80_d_out); end
        repeat (3) @(negedge clk);
        bus_if.z80_m1_n = 1'b1;
        bus_if.z80_iorq_n = 1'b1;
        cnt = 0;
        while (bus_if.z80_d_oe !== 1'b0 && cnt < 6) begin @(negedge clk); cnt++; end
        n_checks++; if (cnt > 3) begin n_fail++; $display("FAIL inta_release got %0d clk want <=3", cnt); end
        n_checks++; if (bus_if.z80_int_n !== 1'b1) begin n_fail++; $display("FAIL inta_int_stays got %b want 1", bus_if.z80_int_n); end
        n_checks++; if ((rd_cnt - rd0) + (wr_cnt - wr0) != 0) begin n_fail++; $display("FAIL inta_strobes got %0d want 0", (rd_cnt - rd0) + (wr_cnt - wr0)); end
        $display("inta: vector=ff int_n released at tick 3");
    endtask

    task automatic test_nmi();
        int cnt, n;
        logic prev, sent;
        @(negedge clk);
        bus_if.nmi_req = 1'b1;
        @(negedge clk);
        bus_if.nmi_req = 1'b0;
        n_checks++; if (bus_if.z80_nmi_n !== 1'b0) begin n_fail++; $display("FAIL nmi_assert got %b want 0", bus_if.z80_nmi_n); end
        prev = bus_if.z80_clk;
        cnt = 0; n = 0; sent = 1'b0;
        while (bus_if.z80_nmi_n !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            bus_if.nmi_req = 1'b0;
            if (!prev && bus_if.z80_clk) cnt++;
            prev = bus_if.z80_clk;
            if (cnt == 5 && !sent) begin
                bus_if.nmi_req = 1'b1;
                sent = 1'b1;
            end
        end
        bus_if.nmi_req = 1'b0;
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL nmi_width got %0d ticks want 16", cnt); end
        repeat (8) @(negedge clk);
        n_checks++; if (bus_if.z80_nmi_n !== 1'b1) begin n_fail++; $display("FAIL nmi_after got %b want 1", bus_if.z80_nmi_n); end
        $display("nmi: low for %0d ticks", cnt);
    endtask

    task automatic test_refresh();
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(negedge clk);
        bus_if.z80_a = 16'h007F;
        bus_if.z80_mreq_n = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (bus_if.z80_d_oe !== 1'b0) begin n_fail++; $display("FAIL refresh_oe got %b want 0", bus_if.z80_d_oe); end
        bus_if.z80_mreq_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if ((rd_cnt - rd0) + (wr_cnt - wr0) != 0) begin n_fail++; $display("FAIL refresh_strobes got %0d want 0", (rd_cnt - rd0) + (wr_cnt - wr0)); end
        $display("refresh: no strobes");
    endtask

    task automatic test_midcycle_reset();
        int lat;
        @(negedge clk);
        rd_value = 8'h5A;
        bus_if.z80_a = 16'h1234;
        bus_if.z80_mreq_n = 1'b0;
        bus_if.z80_rd_n = 1'b0;
        lat = 0;
        while (bus_if.z80_d_oe !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
        n_checks++; if (bus_if.z80_d_out !== 8'h5A) begin n_fail++; $display("FAIL mid_data got %h want 5a", bus_if.z80_d_out); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.z80_mreq_n = 1'b1;
        bus_if.z80_rd_n = 1'b1;
        n_checks++; if (bus_if.z80_d_oe !== 1'b0) begin n_fail++; $display("FAIL mid_oe got %b want 0", bus_if.z80_d_oe); end
        n_checks++; if (bus_if.z80_reset_n !== 1'b0) begin n_fail++; $display("FAIL mid_reset_n got %b want 0", bus_if.z80_reset_n); end
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            n_checks++; if (bus_if.z80_reset_n !== (k >= 64)) begin n_fail++; $display("FAIL mid_seq_reset_n clk=%0d got %b want %b", k, bus_if.z80_reset_n, (k >= 64)); end
            n_checks++; if (bus_if.z80_d_oe !== 1'b0) begin n_fail++; $display("FAIL mid_seq_oe clk=%0d got %b want 0", k, bus_if.z80_d_oe); end
        end
        $display("mid-cycle reset: oe dropped, full reset sequence repeated");
    endtask

    initial begin
        rst = 1'b1;
        bus_if.nmi_req    = 1'b0;
        bus_if.z80_m1_n   = 1'b1;
        bus_if.z80_mreq_n = 1'b1;
        bus_if.z80_iorq_n = 1'b1;
        bus_if.z80_rd_n   = 1'b1;
        bus_if.z80_wr_n   = 1'b1;
        bus_if.z80_a      = 16'h0000;
        bus_if.z80_d_in   = 8'h00;
        test_reset();
        test_int_timing();
        test_mem_read();
        test_io_write();
        test_inta();
        test_nmi();
        test_refresh();
        test_midcycle_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
